traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Demand-actuated phase scheduler for a two-road intersection: NS main road, EW side road. It sequences green, yellow and all-red phases from vehicle-sensor and pedestrian-button inputs, and drives the per-direction light codes and walk signals. It replaces fixed-time sequencing and can optionally give emergency-vehicle preemption to the NS route.

## Interface
- `G_MIN`, default 4: minimum green duration in cycles, either direction.
- `G_MAX`, default 10: maximum EW green duration in cycles.
- `Y_TIME`, default 2: yellow duration in cycles.
- `AR_TIME`, default 1: all-red clearance duration in cycles.
- `WALK_TIME`, default 6: walk-signal duration in cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `car_ew`  in  1  EW vehicle-present sensor, level.
- `ped_req_ns`  in  1  NS-crossing button; a 1-cycle pulse or any high level latches a request.
- `ped_req_ew`  in  1  EW-crossing button; same semantics.
- `preempt`  in  1  emergency preemption request, level.
- `light_ns`  out  3  NS light code: 001 green, 010 yellow, 011 red.
- `light_ew`  out  3  EW light code, same encoding.
- `walk_ns`  out  1  walk permitted parallel to NS traffic.
- `walk_ew`  out  1  walk permitted parallel to EW traffic.
- `phase`  out  3  current state encoding, for debug.

## Operation
- Parameter constraints: all parameters are 1..255, and G_MIN ≤ G_MAX. There are no run-time checks.
- State register and an 8-bit phase timer `t`:
  - `t` is 0 on the first cycle of each state and increments each cycle.
  - "Duration N" means the state is left on the edge where `t == N-1`.
- States and encodings:
  - NS_G (0), NS_Y (1), AR1 (2), EW_G (3), EW_Y (4), AR2 (5), PRE (6).
  - Encoding 7 is unused and recovers to NS_G on the next edge.
- Pedestrian latches `pend_ns` and `pend_ew`:
  - Set whenever the button is high.
  - Cleared on the cycle the matching walk starts.
  - If set and clear coincide, clear wins; the press is consumed.
- Walk windows:
  - `walk_ns` is high for the first WALK_TIME cycles of NS_G if `pend_ns` was set on entry.
  - `walk_ew` likewise for EW_G with `pend_ew`.
- Green minimum `gmin_eff` is G_MIN, or max(G_MIN, WALK_TIME) when a walk is active in that green.
- EW demand = `car_ew | pend_ew`.
- Transitions:
  - NS_G → NS_Y when `t ≥ gmin_eff-1` and EW demand is present. With no demand, NS_G rests indefinitely (`t` saturates at 255).
  - NS_Y → AR1 after Y_TIME cycles.
  - AR1 → EW_G after AR_TIME cycles.
  - EW_G → EW_Y when `t ≥ gmin_eff-1` and `car_ew` == 0, or when `t == G_MAX-1` (forced), whichever comes first. The forced limit still applies if walk extends the green beyond G_MAX: exit is at max(G_MAX, gmin_eff).
  - EW_Y → AR2 after Y_TIME cycles.
  - AR2 → NS_G after AR_TIME cycles.
- Light outputs per state:
  - NS_G: NS 001, EW 011.
  - NS_Y: NS 010, EW 011.
  - EW_G: NS 011, EW 001.
  - EW_Y: NS 011, EW 010.
  - AR1, AR2: both 011.
  - PRE: NS 001, EW 011.
- Walk outputs are 0 outside NS_G/EW_G and always 0 in PRE.

## Timing
- All outputs are registered and change on the same edge as the state. There is no combinational path from input to output.
- Inputs are sampled at edge k. The resulting transition is visible after edge k.
- Reset values:
  - state NS_G, `t` = 0.
  - `light_ns` = 001, `light_ew` = 011.
  - `walk_ns` = `walk_ew` = 0, `phase` = 0, both latches 0.
- Reset mid-operation (any state) takes effect on the next edge, with no yellow or all-red clearance.
- Simultaneous rst and any input: rst wins.

## Configuration
- `TRAFFIC_PREEMPT_EN` defined:
  - `preempt` high in NS_G jumps to PRE with `t` = 0.
  - `preempt` high in EW_G forces EW_Y next edge; EW_Y and AR2 complete normally.
  - AR2 then goes to PRE instead of NS_G if `preempt` is still high; otherwise it goes to NS_G.
  - In NS_Y/AR1 the sequence completes; EW_G is entered then immediately forced out next edge.
  - PRE holds while `preempt` is high. On the edge `preempt` is sampled low, go to NS_G with `t` = 0.
  - Pedestrian latches keep capturing during PRE.
- Undefined: `preempt` is ignored, PRE is unreachable, and encoding 6 recovers to NS_G.

## Test plan
- Reset, all inputs 0 for 50 cycles → `light_ns` 001, `light_ew` 011 throughout; walks 0.
- `car_ew` held 1 from reset → NS green for 4 cycles, NS yellow 2, all-red 1, EW green 10 (forced), EW yellow 2, all-red 1, NS green 4, then repeats.
- `ped_req_ew` 1-cycle pulse at cycle 20, `car_ew` 0 → NS_Y next edge; EW_G lasts 6 cycles with `walk_ew` high all 6; back to NS_G rest; `pend_ew` clear.
- `car_ew` high at cycle 10, drops at EW_G `t` = 1 → EW_G exits at `t` = 3 (G_MIN), EW_Y next.
- With `TRAFFIC_PREEMPT_EN`: `preempt` rises at EW_G `t` = 2 → EW_Y 2 cycles, AR2 1, PRE (NS 001/EW 011) held; `preempt` falls → NS_G with `t` = 0.
- `rst` pulsed during EW_Y `t` = 0 → next cycle NS 001, EW 011, `phase` 0, latches cleared.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated NS/EW phase scheduler with pedestrian walk windows and registered outputs.
// Define TRAFFIC_PREEMPT_EN to enable emergency preemption toward the NS route (PRE state).
module traffic_phase_scheduler #(
    parameter int unsigned G_MIN     = 4,
    parameter int unsigned G_MAX     = 10,
    parameter int unsigned Y_TIME    = 2,
    parameter int unsigned AR_TIME   = 1,
    parameter int unsigned WALK_TIME = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_ew,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       preempt,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StNsG = 3'd0,
        StNsY = 3'd1,
        StAr1 = 3'd2,
        StEwG = 3'd3,
        StEwY = 3'd4,
        StAr2 = 3'd5,
        StPre = 3'd6
    } state_e;

    localparam logic [2:0] LightG = 3'b001;
    localparam logic [2:0] LightY = 3'b010;
    localparam logic [2:0] LightR = 3'b011;

    localparam int unsigned GMinWalk = (G_MIN > WALK_TIME) ? G_MIN : WALK_TIME;
    localparam int unsigned GMaxWalk = (G_MAX > GMinWalk) ? G_MAX : GMinWalk;

    localparam logic [7:0] GMinM1     = 8'(G_MIN - 1);
    localparam logic [7:0] GMaxM1     = 8'(G_MAX - 1);
    localparam logic [7:0] GMinWalkM1 = 8'(GMinWalk - 1);
    localparam logic [7:0] GMaxWalkM1 = 8'(GMaxWalk - 1);
    localparam logic [7:0] YM1        = 8'(Y_TIME - 1);
    localparam logic [7:0] ArM1       = 8'(AR_TIME - 1);
    localparam logic [7:0] WalkLen    = 8'(WALK_TIME);

    state_e     state_q, state_d;
    logic [7:0] t_q, t_d;
    logic       pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic       walk_act_q, walk_act_d;
    logic [2:0] light_ns_q, light_ns_d, light_ew_q, light_ew_d;
    logic       walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic       pre_req;
    logic       pend_ns_set, pend_ew_set;
    logic [7:0] gmin_m1, gmax_m1;

`ifdef TRAFFIC_PREEMPT_EN
    assign pre_req = preempt;
`else
    logic preempt_unused;
    assign preempt_unused = preempt;
    assign pre_req        = 1'b0;
`endif

    // A button high on this edge counts immediately toward demand and walk entry.
    assign pend_ns_set = pend_ns_q | ped_req_ns;
    assign pend_ew_set = pend_ew_q | ped_req_ew;
    assign gmin_m1     = walk_act_q ? GMinWalkM1 : GMinM1;
    assign gmax_m1     = walk_act_q ? GMaxWalkM1 : GMaxM1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNsG: begin
                if (pre_req) begin
                    state_d = StPre;
                end else if ((t_q >= gmin_m1) && (car_ew | pend_ew_set)) begin
                    state_d = StNsY;
                end
            end
            StNsY: if (t_q >= YM1) state_d = StAr1;
            StAr1: if (t_q >= ArM1) state_d = StEwG;
            StEwG: begin
                if (pre_req || ((t_q >= gmin_m1) && !car_ew) || (t_q >= gmax_m1)) begin
                    state_d = StEwY;
                end
            end
            StEwY: if (t_q >= YM1) state_d = StAr2;
            StAr2: if (t_q >= ArM1) state_d = pre_req ? StPre : StNsG;
`ifdef TRAFFIC_PREEMPT_EN
            StPre: if (!pre_req) state_d = StNsG;
`endif
            default: state_d = StNsG;
        endcase
    end

    // Walk windows are decided on green entry, which also consumes the matching request.
    always_comb begin
        pend_ns_d  = pend_ns_set;
        pend_ew_d  = pend_ew_set;
        walk_act_d = walk_act_q;
        t_d        = (t_q == 8'hff) ? t_q : t_q + 8'd1;
        if (state_d != state_q) begin
            t_d        = 8'd0;
            walk_act_d = 1'b0;
            if (state_d == StNsG) begin
                walk_act_d = pend_ns_set;
                pend_ns_d  = 1'b0;
            end
            if (state_d == StEwG) begin
                walk_act_d = pend_ew_set;
                pend_ew_d  = 1'b0;
            end
        end
    end

    always_comb begin
        light_ns_d = LightR;
        light_ew_d = LightR;
        unique case (state_d)
            StNsG, StPre: light_ns_d = LightG;
            StNsY:        light_ns_d = LightY;
            StEwG:        light_ew_d = LightG;
            StEwY:        light_ew_d = LightY;
            default: ;
        endcase
        walk_ns_d = (state_d == StNsG) && walk_act_d && (t_d < WalkLen);
        walk_ew_d = (state_d == StEwG) && walk_act_d && (t_d < WalkLen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StNsG;
            t_q        <= 8'd0;
            pend_ns_q  <= 1'b0;
            pend_ew_q  <= 1'b0;
            walk_act_q <= 1'b0;
            light_ns_q <= LightG;
            light_ew_q <= LightR;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pend_ns_q  <= pend_ns_d;
            pend_ew_q  <= pend_ew_d;
            walk_act_q <= walk_act_d;
            light_ns_q <= light_ns_d;
            light_ew_q <= light_ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
        end
    end

    assign light_ns = light_ns_q;
    assign light_ew = light_ew_q;
    assign walk_ns  = walk_ns_q;
    assign walk_ew  = walk_ew_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a cycle model queues the expected outputs
// per edge, plus directed phase-length checks from the intended sequencing behaviour.
module tb_traffic_phase_scheduler;

    localparam int G_MIN = 4, G_MAX = 10, Y_TIME = 2, AR_TIME = 1, WALK_TIME = 6;
    localparam int WMIN = (G_MIN > WALK_TIME) ? G_MIN : WALK_TIME;
`ifdef TRAFFIC_PREEMPT_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, car_ew = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0, preempt = 1'b0;
    logic [2:0] light_ns, light_ew, phase;
    logic walk_ns, walk_ew;

    traffic_phase_scheduler #(
        .G_MIN(G_MIN), .G_MAX(G_MAX), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME), .WALK_TIME(WALK_TIME)
    ) dut (
        .clk(clk), .rst(rst), .car_ew(car_ew), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .preempt(preempt), .light_ns(light_ns), .light_ew(light_ew), .walk_ns(walk_ns),
        .walk_ew(walk_ew), .phase(phase)
    );

    int checks = 0, errors = 0;
    logic [10:0] exp_q[$];

    // Model state: phase number, timer, request latches, walk-granted flag.
    int m_st = 0, m_t = 0;
    bit m_pns = 0, m_pew = 0, m_wact = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] expect_word(int st, int t, bit wact);
        logic [2:0] lns, lew;
        bit wn, we;
        case (st)
            0, 6:    begin lns = 3'b001; lew = 3'b011; end
            1:       begin lns = 3'b010; lew = 3'b011; end
            3:       begin lns = 3'b011; lew = 3'b001; end
            4:       begin lns = 3'b011; lew = 3'b010; end
            default: begin lns = 3'b011; lew = 3'b011; end
        endcase
        wn = (st == 0) && wact && (t < WALK_TIME);
        we = (st == 3) && wact && (t < WALK_TIME);
        return {lns, lew, wn, we, 3'(st)};
    endfunction

    function automatic logic [10:0] dut_word();
        return {light_ns, light_ew, walk_ns, walk_ew, phase};
    endfunction

    task automatic model_step(input bit r, input bit c, input bit pn, input bit pe, input bit pr);
        int nx, gmin, gmax;
        bit pns, pew, p;
        if (r) begin
            m_st = 0; m_t = 0; m_pns = 0; m_pew = 0; m_wact = 0;
            return;
        end
        p    = pr & PRE_EN;
        pns  = m_pns | pn;
        pew  = m_pew | pe;
        gmin = m_wact ? WMIN : G_MIN;
        gmax = (G_MAX > gmin) ? G_MAX : gmin;
        nx   = m_st;
        case (m_st)
            0: if (p) nx = 6; else if ((c || pew) && (m_t + 1 >= gmin)) nx = 1;
            1: if (m_t + 1 == Y_TIME) nx = 2;
            2: if (m_t + 1 == AR_TIME) nx = 3;
            3: if (p || (m_t + 1 == gmax) || (!c && (m_t + 1 >= gmin))) nx = 4;
            4: if (m_t + 1 == Y_TIME) nx = 5;
            5: if (m_t + 1 == AR_TIME) nx = p ? 6 : 0;
            6: if (!p) nx = 0;
            default: nx = 0;
        endcase
        if (nx != m_st) begin
            m_t = 0;
            m_wact = 0;
            if (nx == 0) begin m_wact = pns; pns = 0; end
            if (nx == 3) begin m_wact = pew; pew = 0; end
        end else if (m_t < 255) begin
            m_t++;
        end
        m_st = nx; m_pns = pns; m_pew = pew;
    endtask

    task automatic step(input bit r, input bit c, input bit pn, input bit pe, input bit pr);
        rst = r; car_ew = c; ped_req_ns = pn; ped_req_ew = pe; preempt = pr;
        model_step(r, c, pn, pe, pr);
        exp_q.push_back(expect_word(m_st, m_t, m_wact));
        @(posedge clk);
        #1;
        check_eq("outputs", 32'(dut_word()), 32'(exp_q.pop_front()));
    endtask

    int exp_ph[7]  = '{0, 1, 2, 3, 4, 5, 0};
    int exp_len[7] = '{4, 2, 1, 10, 2, 1, 4};
    int cur, run, idx, n, len, cnt, cnt2;
    bit rc, rn, re, rp, rr;

    initial begin
        // Reset state and a long idle rest in NS green.
        step(1, 0, 0, 0, 0);
        check_eq("rst_light_ns", light_ns, 3'b001);
        check_eq("rst_light_ew", light_ew, 3'b011);
        check_eq("rst_phase", phase, 0);
        check_eq("rst_walks", {walk_ns, walk_ew}, 2'b00);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0, 0);
            if (light_ns != 3'b001 || light_ew != 3'b011 || walk_ns || walk_ew) cnt++;
        end
        check_eq("idle_rest_bad_cycles", cnt, 0);

        // Continuous EW demand: full cycle with forced EW exit.
        step(1, 0, 0, 0, 0);
        cur = phase; run = 1; idx = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0, 0);
            if (phase == cur) run++;
            else begin
                if (idx < 7) begin
                    check_eq("cycle_phase", cur, exp_ph[idx]);
                    check_eq("cycle_len", run, exp_len[idx]);
                    idx++;
                end
                cur = phase; run = 1;
            end
        end
        check_eq("cycle_runs_seen", idx, 7);

        // EW pedestrian pulse with no cars: walk-extended EW green, then rest.
        step(1, 0, 0, 0, 0);
        repeat (19) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("ped_nsy_next_edge", phase, 1);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0);
            if (phase == 3) cnt++;
            if (walk_ew) cnt2++;
        end
        check_eq("ped_ewg_len", cnt, 6);
        check_eq("ped_walk_len", cnt2, 6);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0);
            if (phase != 0) cnt++;
        end
        check_eq("ped_latch_consumed", cnt, 0);

        // Car leaves early in EW green: exit at minimum green.
        step(1, 0, 0, 0, 0);
        repeat (9) step(0, 0, 0, 0, 0);
        n = 0;
        while (phase != 3 && n < 40) begin step(0, 1, 0, 0, 0); n++; end
        check_eq("gap_reach_ewg", phase, 3);
        len = 1;
        step(0, 1, 0, 0, 0);
        if (phase == 3) len++;
        n = 0;
        while (phase == 3 && n < 20) begin
            step(0, 0, 0, 0, 0);
            if (phase == 3) len++;
            n++;
        end
        check_eq("gap_ewg_len", len, 4);
        check_eq("gap_next_ewy", phase, 4);

`ifdef TRAFFIC_PREEMPT_EN
        // Preemption arriving mid EW green, held, then released.
        step(1, 0, 0, 0, 0);
        n = 0;
        while (phase != 3 && n < 40) begin step(0, 1, 0, 0, 0); n++; end
        check_eq("pre_reach_ewg", phase, 3);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check_eq("pre_ewy", phase, 4);
        step(0, 1, 0, 0, 1);
        check_eq("pre_ewy2", phase, 4);
        step(0, 1, 0, 0, 1);
        check_eq("pre_ar2", phase, 5);
        repeat (5) step(0, 1, 0, 0, 1);
        check_eq("pre_hold", phase, 6);
        check_eq("pre_lights", {light_ns, light_ew}, 6'b001011);
        step(0, 1, 0, 0, 0);
        check_eq("pre_release", phase, 0);
        step(0, 0, 0, 0, 1);
        check_eq("pre_from_nsg", phase, 6);
`endif

        // Reset during EW yellow drops straight to NS green and clears the NS request.
        step(1, 0, 0, 0, 0);
        n = 0;
        while (phase != 3 && n < 40) begin step(0, 1, 0, 0, 0); n++; end
        step(0, 1, 1, 0, 0);
        n = 0;
        while (phase != 4 && n < 40) begin step(0, 1, 0, 0, 0); n++; end
        check_eq("rstmid_reach_ewy", phase, 4);
        step(1, 1, 0, 0, 0);
        check_eq("rstmid_phase", phase, 0);
        check_eq("rstmid_lights", {light_ns, light_ew}, 6'b001011);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(0, 1, 0, 0, 0);
            if (walk_ns) cnt++;
        end
        check_eq("rstmid_no_walk_ns", cnt, 0);

        // Random traffic against the model.
        step(1, 0, 0, 0, 0);
        rc = 0; rp = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rc = ~rc;
            if ($urandom_range(0, 39) == 0) rp = ~rp;
            rn = ($urandom_range(0, 15) == 0);
            re = ($urandom_range(0, 15) == 0);
            rr = ($urandom_range(0, 249) == 0);
            step(rr, rc, rn, re, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
